obi_sram_pipelined: RTL and testbench



---
 rtl/obi_sram_pipelined.sv | 126 ++++++++++++
 tb/tb_obi_sram_pipelined.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_pipelined.sv
// Pipelined single-port OBI SRAM model: one request per cycle, in-order responses
// after READ_LATENCY cycles, out-of-range accesses answered with err_o.
module obi_sram_pipelined #(
    parameter int unsigned MEM_SIZE_BYTE = 32768,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_i,
    output logic                                  gnt_o,
    input  logic [ADDR_WIDTH-1:0]                 addr_i,
    input  logic                                  we_i,
    input  logic [DATA_WIDTH/8-1:0]               be_i,
    input  logic [DATA_WIDTH-1:0]                 wdata_i,
    output logic                                  rvalid_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  err_o,
    output logic [$clog2(READ_LATENCY+1)-1:0]     outstanding_o
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned WORDS     = MEM_SIZE_BYTE / BE_WIDTH;
    localparam int unsigned OFF_BITS  = $clog2(BE_WIDTH);
    localparam int unsigned MEM_BITS  = $clog2(MEM_SIZE_BYTE);
    localparam int unsigned IDX_BITS  = MEM_BITS - OFF_BITS;
    localparam int unsigned CNT_WIDTH = $clog2(READ_LATENCY + 1);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64 || DATA_WIDTH == 128)) begin : g_err_dw
        $error("obi_sram_pipelined: DATA_WIDTH must be 32, 64 or 128");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_err_lat
        $error("obi_sram_pipelined: READ_LATENCY must be within 1..4");
    end
    if ((MEM_SIZE_BYTE & (MEM_SIZE_BYTE - 1)) != 0) begin : g_err_size
        $error("obi_sram_pipelined: MEM_SIZE_BYTE must be a power of 2");
    end

    logic                  accept;
    logic                  in_range;
    logic [IDX_BITS-1:0]   word_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_offset;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic [READ_LATENCY-1:0] valid_d, valid_q;
    logic [READ_LATENCY-1:0] err_d, err_q;
    logic [DATA_WIDTH-1:0]   data_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    assign gnt_o         = req_i && rst_ni;
    assign accept        = req_i && gnt_o;
    assign in_range      = (addr_i[ADDR_WIDTH-1:MEM_BITS] == '0);
    assign word_idx      = addr_i[MEM_BITS-1:OFF_BITS];
    assign unused_offset = ^addr_i[OFF_BITS-1:0];

    // Nonblocking write: a read on the same edge would see the old word, but the
    // single port never accepts both at once.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (be_i[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (accept && !we_i && in_range) begin
            rd_word = mem_q[word_idx];
        end
    end

    // Stage 0 captures the new request; invalid slots carry zero data and no error.
    assign valid_d[0] = accept;
    assign err_d[0]   = accept && !in_range;
    assign data_d[0]  = rd_word;

    for (genvar i = 1; i < READ_LATENCY; i++) begin : g_stage
        assign valid_d[i] = valid_q[i-1];
        assign err_d[i]   = err_q[i-1];
        assign data_d[i]  = data_q[i-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            data_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // The response in the last stage leaves on the next edge.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, rvalid_o})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rvalid_o      = valid_q[READ_LATENCY-1];
    assign err_o         = err_q[READ_LATENCY-1];
    assign rdata_o       = data_q[READ_LATENCY-1];
    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_obi_sram_pipelined.sv
// Directed bench: three instances (32b/L1, 64b/L3, 64b/L4) share one request bus;
// each test checks the instance it targets against hand-computed values.
module tb_obi_sram_pipelined;

    logic        clk = 1'b0;
    logic        rst_n, rst_c;
    logic        req, we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;

    logic        gnt_a, rvalid_a, err_a;
    logic [31:0] rdata_a;
    logic [0:0]  outstanding_a;
    logic        gnt_b, rvalid_b, err_b;
    logic [63:0] rdata_b;
    logic [1:0]  outstanding_b;
    logic        gnt_c, rvalid_c, err_c;
    logic [63:0] rdata_c;
    logic [2:0]  outstanding_c;

    int n_vec;
    int n_err;

    always #5 clk = ~clk;

    obi_sram_pipelined #(
        .MEM_SIZE_BYTE (32768),
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .READ_LATENCY  (1)
    ) u_dut_a (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .gnt_o         (gnt_a),
        .addr_i        (addr),
        .we_i          (we),
        .be_i          (be[3:0]),
        .wdata_i       (wdata[31:0]),
        .rvalid_o      (rvalid_a),
        .rdata_o       (rdata_a),
        .err_o         (err_a),
        .outstanding_o (outstanding_a)
    );

    obi_sram_pipelined #(
        .MEM_SIZE_BYTE (32768),
        .DATA_WIDTH    (64),
        .ADDR_WIDTH    (32),
        .READ_LATENCY  (3)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .gnt_o         (gnt_b),
        .addr_i        (addr),
        .we_i          (we),
        .be_i          (be),
        .wdata_i       (wdata),
        .rvalid_o      (rvalid_b),
        .rdata_o       (rdata_b),
        .err_o         (err_b),
        .outstanding_o (outstanding_b)
    );

    obi_sram_pipelined #(
        .MEM_SIZE_BYTE (32768),
        .DATA_WIDTH    (64),
        .ADDR_WIDTH    (32),
        .READ_LATENCY  (4)
    ) u_dut_c (
        .clk_i         (clk),
        .rst_ni        (rst_c),
        .req_i         (req),
        .gnt_o         (gnt_c),
        .addr_i        (addr),
        .we_i          (we),
        .be_i          (be),
        .wdata_i       (wdata),
        .rvalid_o      (rvalid_c),
        .rdata_o       (rdata_c),
        .err_o         (err_c),
        .outstanding_o (outstanding_c)
    );

    function automatic logic [63:0] pat(input int i);
        return 64'h0BAD_F00D_C0DE_0000 + 64'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [7:0] b,
                         input logic [63:0] d);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        we  = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rst_c = 1'b0;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 32'h10;
        be    = 8'h00;
        wdata = 64'h0;
        #2;
        // Reset state, with a request pending
        check("rst_gnt_a", gnt_a, 0);
        check("rst_gnt_c", gnt_c, 0);
        check("rst_rvalid_a", rvalid_a, 0);
        check("rst_rdata_a", rdata_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_out_b", outstanding_b, 0);
        step();
        step();
        req   = 1'b0;
        rst_n = 1'b1;
        rst_c = 1'b1;
        step();

        // Test 1: write then read, 32-bit, latency 1
        drive(1'b1, 32'h10, 8'h0F, 64'h0000_0000_DEAD_BEEF);
        check("t1_gnt", gnt_a, 1);
        step();
        check("t1_wr_rvalid", rvalid_a, 1);
        check("t1_wr_err", err_a, 0);
        check("t1_wr_rdata", rdata_a, 0);
        check("t1_wr_out", outstanding_a, 1);
        drive(1'b0, 32'h10, 8'h00, 64'h0);
        step();
        check("t1_rd_rvalid", rvalid_a, 1);
        check("t1_rd_rdata", rdata_a, 32'hDEAD_BEEF);
        check("t1_rd_err", err_a, 0);
        check("t1_rd_out", outstanding_a, 1);
        idle(1);
        check("t1_end_rvalid", rvalid_a, 0);
        check("t1_end_rdata", rdata_a, 0);
        check("t1_end_out", outstanding_a, 0);
        idle(4);

        // Test 2: byte enables, 64-bit, latency 3
        drive(1'b1, 32'h0, 8'hFF, 64'h1122_3344_5566_7788);
        step();
        drive(1'b1, 32'h0, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA);
        step();
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        step();
        idle(1);
        check("t2_wr_rvalid", rvalid_b, 1);
        check("t2_wr_rdata", rdata_b, 0);
        step();
        check("t2_rd_rvalid", rvalid_b, 1);
        check("t2_rd_rdata", rdata_b, 64'h1122_3344_AAAA_AAAA);
        check("t2_rd_err", err_b, 0);
        step();
        check("t2_end_rvalid", rvalid_b, 0);
        idle(4);

        // Test 3: preload, then 8 back-to-back reads at latency 3
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 8), 8'hFF, pat(i));
            step();
        end
        idle(4);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'(i * 8), 8'h00, 64'h0);
            check("t3_gnt", gnt_b, 1);
            step();
            check("t3_out", outstanding_b, (i < 2) ? i + 1 : 3);
            if (i >= 2) begin
                check("t3_rvalid", rvalid_b, 1);
                check("t3_rdata", rdata_b, pat(i - 2));
            end else begin
                check("t3_early_rvalid", rvalid_b, 0);
            end
        end
        req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t3_tail_rvalid", rvalid_b, 1);
            check("t3_tail_rdata", rdata_b, pat(6 + k));
            check("t3_tail_out", outstanding_b, 2 - k);
        end
        step();
        check("t3_end_rvalid", rvalid_b, 0);
        check("t3_end_out", outstanding_b, 0);
        idle(2);

        // Test 4: out-of-range accesses on the 32-bit instance
        drive(1'b1, 32'h8000, 8'h0F, 64'h1234_5678);
        step();
        check("t4_wr_rvalid", rvalid_a, 1);
        check("t4_wr_err", err_a, 1);
        check("t4_wr_rdata", rdata_a, 0);
        drive(1'b0, 32'h8000, 8'h00, 64'h0);
        step();
        check("t4_rd_rvalid", rvalid_a, 1);
        check("t4_rd_err", err_a, 1);
        check("t4_rd_rdata", rdata_a, 0);
        drive(1'b0, 32'h0, 8'h00, 64'h0);
        step();
        check("t4_w0_rvalid", rvalid_a, 1);
        check("t4_w0_err", err_a, 0);
        check("t4_w0_rdata", rdata_a, 32'hC0DE_0000);
        idle(1);
        check("t4_end_rvalid", rvalid_a, 0);
        check("t4_end_err", err_a, 0);
        idle(5);

        // Test 5: reset mid-stream at latency 4
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'(i * 8), 8'h00, 64'h0);
            step();
        end
        check("t5_pre_out", outstanding_c, 3);
        check("t5_pre_rvalid", rvalid_c, 0);
        rst_c = 1'b0;
        drive(1'b0, 32'h18, 8'h00, 64'h0);
        check("t5_rst_rvalid", rvalid_c, 0);
        check("t5_rst_out", outstanding_c, 0);
        check("t5_rst_gnt", gnt_c, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("t5_rst_hold_rvalid", rvalid_c, 0);
            check("t5_rst_hold_gnt", gnt_c, 0);
        end
        rst_c = 1'b1;
        req   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_post_rvalid", rvalid_c, 0);
            check("t5_post_out", outstanding_c, 0);
        end
        drive(1'b0, 32'h8, 8'h00, 64'h0);
        step();
        req = 1'b0;
        step();
        step();
        check("t5_reread_early", rvalid_c, 0);
        step();
        check("t5_reread_rvalid", rvalid_c, 1);
        check("t5_reread_rdata", rdata_c, pat(1));
        check("t5_reread_err", err_c, 0);
        idle(5);

        // Test 6: idle
        for (int k = 0; k < 10; k++) begin
            step();
            check("t6_gnt_a", gnt_a, 0);
            check("t6_rvalid_a", rvalid_a, 0);
            check("t6_rdata_a", rdata_a, 0);
            check("t6_rvalid_b", rvalid_b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
